// File: rtl/rv_fetch_unit.sv
// Instruction fetch unit: issues single-outstanding word reads and buffers
// {pc, instr} pairs in a small FIFO for a multicycle core; redirects flush and restart.
module rv_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, drain_addr;
    logic [31:0]   pc_mem [FIFO_DEPTH];
    logic [31:0]   ir_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_after;
    logic          push, pop;
    logic          unused_rpc;

    assign unused_rpc  = ^redirect_pc[1:0];
    assign push        = (state == REQ) && imem_ack && !redirect_valid;
    assign pop         = inst_valid && inst_ready && !redirect_valid;
    assign count_after = count + CW'(push) - CW'(pop);

    assign imem_req   = (state != IDLE);
    // DRAIN keeps presenting the abandoned address until memory answers it
    assign imem_addr  = (state == DRAIN) ? drain_addr : fetch_pc;
    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? ir_mem[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr] : 32'h0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (redirect_valid || (count < DEPTH_C)) state_nxt = REQ;
            REQ: begin
                if (redirect_valid)  state_nxt = imem_ack ? REQ : DRAIN;
                else if (imem_ack)   state_nxt = (count_after < DEPTH_C) ? REQ : IDLE;
            end
            DRAIN: if (imem_ack) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                if ((state == REQ) && !imem_ack) drain_addr <= fetch_pc;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count_after;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr] <= fetch_pc;
            ir_mem[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: per-cycle vector table plus reset/backpressure sequences.
module tb_rv_fetch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // memory model: data is a fixed function of the requested address
    assign imem_rdata = word(imem_addr);

    rv_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rv, input logic [31:0] rpc, input logic ack, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                       input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic ack, input logic rdy);
        redirect_valid = rv; redirect_pc = rpc; imem_ack = ack; inst_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int acks;
    bit seen;

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        chk("rst_req",  {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_vld",  {31'h0, inst_valid}, 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc",   inst_pc, 32'h0);

        //   rv  rpc            ack rdy  req addr           vld pc
        add(0, 32'h0,        0, 1,  0, 32'h0,        0, 32'h0);
        add(0, 32'h0,        1, 1,  1, 32'h0,        0, 32'h0);
        add(0, 32'h0,        1, 1,  1, 32'h4,        1, 32'h0);
        add(0, 32'h0,        1, 1,  1, 32'h8,        1, 32'h4);
        add(0, 32'h0,        1, 1,  1, 32'hC,        1, 32'h8);
        add(0, 32'h0,        1, 1,  1, 32'h10,       1, 32'hC);
        add(0, 32'h0,        1, 0,  1, 32'h14,       1, 32'h10);
        add(0, 32'h0,        0, 0,  0, 32'h18,       1, 32'h10);
        add(0, 32'h0,        0, 0,  0, 32'h18,       1, 32'h10);
        add(0, 32'h0,        0, 1,  0, 32'h18,       1, 32'h10);
        add(0, 32'h0,        0, 1,  0, 32'h18,       1, 32'h14);
        add(0, 32'h0,        1, 1,  1, 32'h18,       0, 32'h0);
        add(0, 32'h0,        0, 1,  1, 32'h1C,       1, 32'h18);
        add(0, 32'h0,        0, 1,  1, 32'h1C,       0, 32'h0);
        add(0, 32'h0,        0, 1,  1, 32'h1C,       0, 32'h0);
        add(0, 32'h0,        1, 0,  1, 32'h1C,       0, 32'h0);
        add(0, 32'h0,        0, 0,  1, 32'h20,       1, 32'h1C);
        add(1, 32'h100,      0, 0,  1, 32'h20,       1, 32'h1C);
        add(0, 32'h0,        0, 0,  1, 32'h20,       0, 32'h0);
        add(0, 32'h0,        1, 0,  1, 32'h20,       0, 32'h0);
        add(0, 32'h0,        1, 0,  1, 32'h100,      0, 32'h0);
        add(1, 32'h203,      1, 1,  1, 32'h104,      1, 32'h100);
        add(0, 32'h0,        1, 0,  1, 32'h200,      0, 32'h0);
        add(1, 32'h300,      0, 0,  1, 32'h204,      1, 32'h200);
        add(1, 32'h400,      0, 0,  1, 32'h204,      0, 32'h0);
        add(0, 32'h0,        1, 0,  1, 32'h204,      0, 32'h0);
        add(0, 32'h0,        1, 0,  1, 32'h400,      0, 32'h0);
        add(1, 32'hFFFF_FFFC,1, 0,  1, 32'h404,      1, 32'h400);
        add(0, 32'h0,        1, 0,  1, 32'hFFFF_FFFC,0, 32'h0);
        add(0, 32'h0,        1, 0,  1, 32'h0,        1, 32'hFFFF_FFFC);
        add(0, 32'h0,        0, 1,  0, 32'h4,        1, 32'hFFFF_FFFC);
        add(0, 32'h0,        0, 1,  0, 32'h4,        1, 32'h0);
        add(0, 32'h0,        0, 1,  1, 32'h4,        0, 32'h0);

        @(negedge clock);
        reset = 1'b0;
        foreach (tbl[i]) begin
            if (i != 0) @(negedge clock);
            drive(tbl[i].rv, tbl[i].rpc, tbl[i].ack, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d_req", i),  {31'h0, imem_req},   {31'h0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr,           tbl[i].e_addr);
            chk($sformatf("v%0d_vld", i),  {31'h0, inst_valid}, {31'h0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("v%0d_pc", i),   inst_pc,   tbl[i].e_pc);
                chk($sformatf("v%0d_data", i), inst_data, word(tbl[i].e_pc));
            end
        end

        // backpressure from reset: exactly two words accepted, head held at 0
        do_reset();
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 32'h0, imem_req, 1'b0);
            if (imem_req) acks++;
            if (c >= 3) begin
                chk("bp_req_low", {31'h0, imem_req}, 32'h0);
                chk("bp_pc_hold", inst_pc, 32'h0);
                chk("bp_data_hold", inst_data, word(32'h0));
            end
            @(negedge clock);
        end
        chk("bp_acks", acks, 32'd2);

        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            if (imem_req) begin
                seen = 1'b1;
                chk("bp_resume_addr", imem_addr, 32'h8);
            end
            @(negedge clock);
        end
        if (!seen) chk("bp_resume_timeout", 32'h0, 32'h1);

        // refill under backpressure, then reset asynchronously mid-cycle
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, imem_req, 1'b0);
            @(negedge clock);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_vld", {31'h0, inst_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_vld",  {31'h0, inst_valid}, 32'h0);
        chk("arst_req",  {31'h0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_pc",   inst_pc, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_req0", {31'h0, imem_req}, 32'h0);
        @(negedge clock);
        #1;
        chk("rel_req1",  {31'h0, imem_req}, 32'h1);
        chk("rel_addr1", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
